// File: rtl/branch_predictor_table.sv
// Table of saturating counters indexed by PC, with a saturating misprediction counter.
// Optional gshare indexing (global history XOR PC) is enabled by defining BPRED_GSHARE_EN.
module branch_predictor_table #(
    parameter int               CTR_W    = 2,
    parameter int               IDX_W    = 6,
    parameter logic [CTR_W-1:0] CTR_INIT = 2'b10,
    parameter int               GHR_W    = IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             branch_i,
    input  logic [31:0]      pc_i,
    output logic             prediction_o,
    output logic [IDX_W-1:0] lookup_idx_o,
    input  logic             update_valid_i,
    input  logic [IDX_W-1:0] update_idx_i,
    input  logic             update_pred_i,
    input  logic             branch_taken_i,
    output logic [31:0]      mispredict_cnt_o
);

    localparam int               TBL_N   = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [CTR_W-1:0] ctr_tbl [TBL_N];
    logic [31:0]      mispredict_cnt;
    logic [IDX_W-1:0] pc_idx;

    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] cur,
                                                  input logic             taken);
        if (taken)
            return (cur == CTR_MAX) ? cur : cur + 1'b1;
        else
            return (cur == '0) ? cur : cur - 1'b1;
    endfunction

    function automatic logic [31:0] cnt_sat_inc(input logic [31:0] cur);
        return (cur == 32'hFFFF_FFFF) ? cur : cur + 32'd1;
    endfunction

    assign pc_idx = pc_i[IDX_W+1:2];

    logic unused_pc;
    assign unused_pc = ^{pc_i[31:IDX_W+2], pc_i[1:0]};

`ifdef BPRED_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    assign lookup_idx_o = pc_idx ^ IDX_W'(ghr);

    // Newest outcome enters at bit 0; the cast drops the oldest bit.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            ghr <= '0;
        else if (update_valid_i)
            ghr <= GHR_W'({ghr, branch_taken_i});
    end
`else
    assign lookup_idx_o = pc_idx;

    logic unused_cfg;
    assign unused_cfg = ^GHR_W;
`endif

    // No bypass: a same-cycle update becomes visible on the following cycle.
    assign prediction_o = branch_i & ctr_tbl[lookup_idx_o][CTR_W-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TBL_N; i++)
                ctr_tbl[i] <= CTR_INIT;
        end else if (update_valid_i) begin
            ctr_tbl[update_idx_i] <= ctr_next(ctr_tbl[update_idx_i], branch_taken_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            mispredict_cnt <= '0;
        else if (update_valid_i && (update_pred_i != branch_taken_i))
            mispredict_cnt <= cnt_sat_inc(mispredict_cnt);
    end

    assign mispredict_cnt_o = mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed bench for branch_predictor_table: behavioural model compared every cycle,
// plus literal expectations for the reset, saturation, collision and mispredict scenarios.
module tb_branch_predictor_table;

    localparam int CTR_W = 2;
    localparam int IDX_W = 6;
    localparam int N     = 64;
    localparam int CMAX  = 3;

    logic             clk = 0;
    logic             rst_i = 1;
    logic             branch_i = 0;
    logic [31:0]      pc_i = '0;
    logic             prediction_o;
    logic [IDX_W-1:0] lookup_idx_o;
    logic             update_valid_i = 0;
    logic [IDX_W-1:0] update_idx_i = '0;
    logic             update_pred_i = 0;
    logic             branch_taken_i = 0;
    logic [31:0]      mispredict_cnt_o;

    int total = 0;
    int bad   = 0;

    branch_predictor_table #(.CTR_W(CTR_W), .IDX_W(IDX_W), .CTR_INIT(2'b10)) dut (
        .clk_i(clk), .rst_i(rst_i), .branch_i(branch_i), .pc_i(pc_i),
        .prediction_o(prediction_o), .lookup_idx_o(lookup_idx_o),
        .update_valid_i(update_valid_i), .update_idx_i(update_idx_i),
        .update_pred_i(update_pred_i), .branch_taken_i(branch_taken_i),
        .mispredict_cnt_o(mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain integers, history kept as a bit list value.
    int     m_ctr [N];
    longint m_mis = 0;
    int     m_ghr = 0;
    bit     m_ok  = 0;

    function automatic int exp_idx(input logic [31:0] pc);
        int i;
        i = (pc / 4) % N;
`ifdef BPRED_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    function automatic logic [31:0] pc_for(input int idx);
        int i;
        i = idx;
`ifdef BPRED_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return 32'(i * 4);
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) m_ctr[i] = 2;
            m_mis = 0;
            m_ghr = 0;
            m_ok  = 1;
        end else if (update_valid_i) begin
            if (branch_taken_i) begin
                if (m_ctr[update_idx_i] < CMAX) m_ctr[update_idx_i]++;
            end else begin
                if (m_ctr[update_idx_i] > 0) m_ctr[update_idx_i]--;
            end
            if (update_pred_i != branch_taken_i && m_mis < 64'hFFFF_FFFF) m_mis++;
            m_ghr = ((m_ghr * 2) + int'(branch_taken_i)) % N;
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok && !rst_i) begin
            int ei;
            ei = exp_idx(pc_i);
            chk("model_idx", longint'(lookup_idx_o), longint'(ei));
            chk("model_pred", longint'(prediction_o),
                longint'(branch_i && (m_ctr[ei] >= 2)));
            chk("model_mis", longint'(mispredict_cnt_o), m_mis);
        end
    end

    task automatic upd(input int idx, input bit taken, input bit pred);
        @(posedge clk); #1;
        update_valid_i = 1;
        update_idx_i   = IDX_W'(idx);
        branch_taken_i = taken;
        update_pred_i  = pred;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            update_valid_i = 0;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst_i = 1;
        repeat (n) @(posedge clk);
        #1 rst_i = 0;
        update_valid_i = 0;
    endtask

    initial begin
        // Reset with an update pending: it must be discarded.
        update_valid_i = 1; update_idx_i = 16; branch_taken_i = 0; update_pred_i = 1;
        repeat (3) @(posedge clk);
        #1 rst_i = 0; update_valid_i = 0;
        branch_i = 1; pc_i = 32'h40;
        #1;
        chk("reset_idx", longint'(lookup_idx_o), 16);
        chk("reset_pred", longint'(prediction_o), 1);
        chk("reset_mis", longint'(mispredict_cnt_o), 0);
        chk("reset_ctr16", longint'(dut.ctr_tbl[16]), 2);

        // Saturation down at idx 16.
        for (int k = 0; k < 3; k++) upd(16, 0, 1);
        idle(1);
        pc_i = pc_for(16); #1;
        chk("satdn_ctr", longint'(dut.ctr_tbl[16]), 0);
        chk("satdn_pred", longint'(prediction_o), 0);
        upd(16, 1, 0);
        idle(1);
        pc_i = pc_for(16); #1;
        chk("satdn_up_ctr", longint'(dut.ctr_tbl[16]), 1);
        chk("satdn_up_pred", longint'(prediction_o), 0);
        chk("model_ctr16", longint'(m_ctr[16]), 1);

        // Saturation up at idx 5.
        for (int k = 0; k < 5; k++) upd(5, 1, 1);
        idle(1);
        #1;
        chk("satup_ctr", longint'(dut.ctr_tbl[5]), 3);
        chk("neighbour_ctr4", longint'(dut.ctr_tbl[4]), 2);
        upd(5, 0, 1);
        idle(1);
        pc_i = pc_for(5); #1;
        chk("satup_dn_ctr", longint'(dut.ctr_tbl[5]), 2);
        chk("satup_dn_pred", longint'(prediction_o), 1);

        // Lookup and update to the same index in one cycle.
        @(posedge clk); #1;
        pc_i = pc_for(16); branch_i = 1;
        update_valid_i = 1; update_idx_i = 16; branch_taken_i = 1; update_pred_i = 0;
        #1;
        chk("collide_now", longint'(prediction_o), 0);
        @(posedge clk); #1;
        update_valid_i = 0; pc_i = pc_for(16); #1;
        chk("collide_next", longint'(prediction_o), 1);

        // branch_i low forces not-taken regardless of table contents.
        branch_i = 0; pc_i = pc_for(5); #1;
        chk("nobranch_pred", longint'(prediction_o), 0);
        branch_i = 1;

        // Mixed directed traffic across several indices, model-checked.
        for (int k = 0; k < 24; k++) begin
            upd((k * 7) % N, bit'((k % 3) != 0), bit'(k % 2));
            pc_i = 32'(((k * 5) % N) * 4 + 32'h1000);
        end
        idle(2);

        // Reset arriving mid-sequence discards that update.
        upd(9, 1, 0);
        @(posedge clk); #1;
        rst_i = 1; update_idx_i = 9; branch_taken_i = 0;
        @(posedge clk); #1;
        rst_i = 0;
        update_idx_i = 10; branch_taken_i = 1; update_pred_i = 1;
        idle(1);
        #1;
        chk("midrst_ctr9", longint'(dut.ctr_tbl[9]), 2);
        chk("midrst_ctr10", longint'(dut.ctr_tbl[10]), 3);

        // Mispredict count.
        do_reset(1);
        upd(1, 0, 1);
        upd(2, 0, 0);
        upd(3, 1, 0);
        upd(4, 1, 1);
        idle(1);
        #1;
        chk("mis_count", longint'(mispredict_cnt_o), 2);
        idle(3);
        chk("mis_hold", longint'(mispredict_cnt_o), 2);

`ifdef BPRED_GSHARE_EN
        do_reset(1);
        upd(0, 1, 1);
        upd(0, 0, 0);
        idle(1);
        pc_i = 32'h40; #1;
        chk("gshare_ghr", longint'(dut.ghr[1:0]), 2);
        chk("gshare_idx", longint'(lookup_idx_o), 18);
`endif

        do_reset(1);
        #1;
        chk("mis_reset", longint'(mispredict_cnt_o), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
